// File: rtl/rr_grant_arbiter_pkg.sv
// Shared sizing constants and FSM state encoding for the round-robin grant arbiter.
package rr_grant_arbiter_pkg;

    localparam int unsigned N        = 32;
    localparam int unsigned IDXW     = 5;
    localparam int unsigned MAX_HOLD = 16;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_grant_arbiter_if;
    import rr_grant_arbiter_pkg::*;

    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_valid;
    logic            timeout;

    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );

endinterface

// File: rtl/rr_grant_arbiter_onehot_dec5.sv
// Combinational 5-to-32 one-hot decoder used to form the grant vector from the holder index.
module onehot_dec5
    import rr_grant_arbiter_pkg::*;
(
    input  logic [IDXW-1:0] idx_i,
    output logic [N-1:0]    onehot_o
);

    assign onehot_o = N'(1) << idx_i;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: one holder at a time, released by done, request drop or hold timeout.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int unsigned MaxHold = MAX_HOLD
) (
    input logic                clk,
    input logic                rst,
    rr_grant_arbiter_if.slave  bus
);

    localparam logic [7:0] HoldLast = 8'(MaxHold - 1);

    state_e          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [7:0]      hold_cnt_q, hold_cnt_d;
    logic            timeout_q, timeout_d;

    logic [N-1:0]    rot;
    logic [IDXW-1:0] off;
    logic [IDXW-1:0] winner;
    logic [N-1:0]    dec;

    // Rotate so ptr lands at bit 0; lowest set bit of rot is the winner's offset from ptr.
    always_comb begin
        rot = N'({bus.req, bus.req} >> ptr_q);
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = IDXW'(i);
        end
        winner = off + ptr_q;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    state_d    = StGrant;
                    idx_d      = winner;
                    hold_cnt_d = '0;
                end
            end
            StGrant: begin
                hold_cnt_d = hold_cnt_q + 8'd1;
                if (bus.done || !bus.req[idx_q] || hold_cnt_q == HoldLast) begin
                    state_d    = StIdle;
                    idx_d      = '0;
                    hold_cnt_d = '0;
                    ptr_d      = idx_q + IDXW'(1);
                    // done and a dropped request both take priority over the forced release.
                    timeout_d  = !bus.done && bus.req[idx_q];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            idx_q      <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    onehot_dec5 u_dec (
        .idx_i    (idx_q),
        .onehot_o (dec)
    );

    assign bus.gnt_valid = (state_q == StGrant);
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt       = dec & {N{bus.gnt_valid}};
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed plus randomized bench for rr_grant_arbiter against a transaction-level model.
module tb_rr_grant_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    rr_grant_arbiter_if bus_if ();

    rr_grant_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model: who holds the resource, for how long, and where the scan starts next.
    bit m_busy;
    int m_idx;
    int m_cycles;
    int m_ptr;
    bit m_to;

    task automatic model_edge(input logic [31:0] r, input logic d, input logic rs);
        if (rs) begin
            m_busy = 0; m_idx = 0; m_cycles = 0; m_ptr = 0; m_to = 0;
        end else if (!m_busy) begin
            m_to = 0;
            for (int k = 0; k < 32; k++) begin
                if (!m_busy && r[(m_ptr + k) % 32]) begin
                    m_busy   = 1;
                    m_idx    = (m_ptr + k) % 32;
                    m_cycles = 1;
                end
            end
        end else begin
            m_to = 0;
            if (d || !r[m_idx]) begin
                m_busy = 0; m_ptr = (m_idx + 1) % 32; m_idx = 0;
            end else if (m_cycles == 16) begin
                m_busy = 0; m_ptr = (m_idx + 1) % 32; m_idx = 0; m_to = 1;
            end else begin
                m_cycles++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] eg;
        eg = m_busy ? (32'd1 << m_idx) : 32'd0;
        chk({tag, ".gnt"}, bus_if.gnt, eg);
        chk({tag, ".gnt_idx"}, 32'(bus_if.gnt_idx), 32'(m_idx));
        chk({tag, ".gnt_valid"}, 32'(bus_if.gnt_valid), 32'(m_busy));
        chk({tag, ".timeout"}, 32'(bus_if.timeout), 32'(m_to));
    endtask

    task automatic cyc(input string tag, input logic [31:0] r, input logic d, input logic rs);
        bus_if.req  = r;
        bus_if.done = d;
        rst         = rs;
        @(posedge clk);
        model_edge(r, d, rs);
        #1;
        check_model(tag);
    endtask

    initial begin
        int exp2 [4];
        logic [31:0] r;
        logic [31:0] masks [4];
        bus_if.req  = '0;
        bus_if.done = 1'b0;
        rst         = 1'b1;

        // 1: reset with all requests, first grant is idx 0
        cyc("t1.rst0", 32'hFFFF_FFFF, 1'b0, 1'b1);
        cyc("t1.rst1", 32'hFFFF_FFFF, 1'b0, 1'b1);
        chk("t1.rst_valid", 32'(bus_if.gnt_valid), 32'd0);
        cyc("t1.grant", 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("t1.first_idx", 32'(bus_if.gnt_idx), 32'd0);
        cyc("t1.rel", 32'h0000_0011, 1'b1, 1'b0);

        // 2: two requesters alternate with done each grant
        exp2 = '{4, 0, 4, 0};
        for (int k = 0; k < 4; k++) begin
            cyc("t2.grant", 32'h0000_0011, 1'b0, 1'b0);
            chk("t2.idx", 32'(bus_if.gnt_idx), 32'(exp2[k]));
            cyc("t2.rel", 32'h0000_0011, 1'b1, 1'b0);
            chk("t2.gap", bus_if.gnt, 32'd0);
        end

        // 3: pointer wrap from 31 to 0
        cyc("t3.rst", 32'h0, 1'b0, 1'b1);
        cyc("t3.g30", 32'h4000_0000, 1'b0, 1'b0);
        chk("t3.idx30", 32'(bus_if.gnt_idx), 32'd30);
        cyc("t3.rel30", 32'h8000_0001, 1'b1, 1'b0);
        cyc("t3.g31", 32'h8000_0001, 1'b0, 1'b0);
        chk("t3.idx31", 32'(bus_if.gnt_idx), 32'd31);
        cyc("t3.rel31", 32'h8000_0001, 1'b1, 1'b0);
        cyc("t3.g0", 32'h8000_0001, 1'b0, 1'b0);
        chk("t3.idx0", 32'(bus_if.gnt_idx), 32'd0);

        // 4: single holder times out after 16 cycles, then is re-granted
        cyc("t4.rst", 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            cyc("t4.hold", 32'h0000_0004, 1'b0, 1'b0);
            chk("t4.valid", 32'(bus_if.gnt_valid), 32'd1);
        end
        cyc("t4.to", 32'h0000_0004, 1'b0, 1'b0);
        chk("t4.pulse", 32'(bus_if.timeout), 32'd1);
        chk("t4.gap", 32'(bus_if.gnt_valid), 32'd0);
        cyc("t4.regrant", 32'h0000_0004, 1'b0, 1'b0);
        chk("t4.idx2", 32'(bus_if.gnt_idx), 32'd2);
        chk("t4.pulse_end", 32'(bus_if.timeout), 32'd0);

        // 5: done on the last hold cycle beats timeout; request drop also releases quietly
        for (int k = 0; k < 15; k++) cyc("t5.hold", 32'h0000_0004, 1'b0, 1'b0);
        cyc("t5.done", 32'h0000_0004, 1'b1, 1'b0);
        chk("t5.no_to", 32'(bus_if.timeout), 32'd0);
        chk("t5.rel", 32'(bus_if.gnt_valid), 32'd0);
        cyc("t5.idle_done", 32'h0, 1'b1, 1'b0);
        cyc("t5.grant", 32'h0000_0004, 1'b0, 1'b0);
        cyc("t5.hold2", 32'h0000_0006, 1'b0, 1'b0);
        chk("t5.no_preempt", 32'(bus_if.gnt_idx), 32'd2);
        cyc("t5.drop", 32'h0, 1'b0, 1'b0);
        chk("t5.drop_no_to", 32'(bus_if.timeout), 32'd0);

        // 6: reset during a grant clears the pointer
        cyc("t6.rst", 32'h0, 1'b0, 1'b1);
        cyc("t6.g9", 32'h0000_0200, 1'b0, 1'b0);
        chk("t6.idx9", 32'(bus_if.gnt_idx), 32'd9);
        cyc("t6.midrst", 32'h0000_0A08, 1'b0, 1'b1);
        chk("t6.cleared", bus_if.gnt, 32'd0);
        cyc("t6.lowest", 32'h0000_0A08, 1'b0, 1'b0);
        chk("t6.idx3", 32'(bus_if.gnt_idx), 32'd3);

        // Randomized bursts of held request patterns against the model
        masks[0] = 32'hFFFF_FFFF;
        masks[1] = 32'h0000_00FF;
        masks[2] = 32'h8000_0003;
        masks[3] = 32'h0101_0101;
        for (int b = 0; b < 150; b++) begin
            r = $urandom() & masks[$urandom_range(0, 3)];
            for (int k = 0; k < int'($urandom_range(1, 22)); k++) begin
                if ($urandom_range(0, 7) == 0) r = r ^ (32'd1 << $urandom_range(0, 31));
                cyc("rand", r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
